mult_sequencer: RTL and testbench

//   Control stage that drives the shift-add multiplier and consumes its 64-bit product.
//   On each accepted request it:
//   - latches the operands and pulses the multiplier load;
//   - issues WIDTH MULTU cycles, then one OUT cycle;
//   - captures the product into HI/LO.

---
 rtl/mult_sequencer_pkg.sv | 20 ++
 rtl/mult_sequencer_if.sv | 21 ++
 rtl/mult_sequencer_hilo.sv | 34 +++
 rtl/mult_sequencer.sv | 121 ++++++++++++
 tb/tb_mult_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_sequencer_pkg.sv
// Shared multiplier definitions: command codes, read-function codes and the
// sequencer FSM encoding. Used by the multiplier, ALU and mult_sequencer.
package mult_defs;

  localparam logic [5:0] MULTU_CODE = 6'd25;
  localparam logic [5:0] OUT_CODE   = 6'd63;
  localparam logic [5:0] IDLE_CODE  = 6'd0;

  localparam logic [5:0] MFHI_FN = 6'd16;
  localparam logic [5:0] MFLO_FN = 6'd18;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    OUT  = 3'd3,
    CAPT = 3'd4
  } state_t;

endpackage

// File: rtl/mult_sequencer_if.sv
// Sequencer <-> shift-add multiplier bus. The sequencer is master (drives the
// command, load and operands); the multiplier is slave (returns the product).
interface mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic               mul_load;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [5:0]         mul_signal;
  logic [2*WIDTH-1:0] mul_result;

  modport master (
    output mul_load, mul_a, mul_b, mul_signal,
    input  mul_result
  );

  modport slave (
    input  mul_load, mul_a, mul_b, mul_signal,
    output mul_result
  );
endinterface

// File: rtl/mult_sequencer_hilo.sv
// HI/LO product register with synchronous clear, write enable and the
// MFHI/MFLO read mux (combinational, no bypass of a same-cycle write).
module hilo_reg
  import mult_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               we,
  input  logic [2*WIDTH-1:0] wdata,
  input  logic [5:0]         rd_fn,
  output logic [WIDTH-1:0]   rd_data,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  always_ff @(posedge clk) begin
    if (clr) begin
      hi <= '0;
      lo <= '0;
    end else if (we) begin
      hi <= wdata[2*WIDTH-1:WIDTH];
      lo <= wdata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_fn == MFHI_FN)      rd_data = hi;
    else if (rd_fn == MFLO_FN) rd_data = lo;
  end

endmodule

// File: rtl/mult_sequencer.sv
// Multiplier control stage: latches operands, sequences LOAD / WIDTH x MULTU /
// OUT, captures the product into HI/LO. Optional MULT_SIGNED_EN adds signed MULT.
module mult_sequencer
  import mult_defs::*;
#(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] MULTU_CODE = mult_defs::MULTU_CODE,
  parameter logic [5:0] OUT_CODE   = mult_defs::OUT_CODE,
  parameter logic [5:0] IDLE_CODE  = mult_defs::IDLE_CODE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
`ifdef MULT_SIGNED_EN
  input  logic             op_signed,
`endif
  output logic             ready,
  output logic             done,
  mult_sequencer_if.master mul,
  input  logic [5:0]       rd_fn,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state, state_nx;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     op_a, op_b;
  logic                 neg;
  logic                 accept;
  logic                 load_o;
  logic [5:0]           sig_o;
  logic [2*WIDTH-1:0]   wdata;

  assign accept = start && (state == IDLE);

`ifdef MULT_SIGNED_EN
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = ITER;
      ITER:    if (cnt == LAST) state_nx = OUT;
      OUT:     state_nx = CAPT;
      CAPT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready  = 1'b0;
    done   = 1'b0;
    load_o = 1'b0;
    sig_o  = IDLE_CODE;
    unique case (state)
      IDLE:    ready  = 1'b1;
      LOAD:    load_o = 1'b1;
      ITER:    sig_o  = MULTU_CODE;
      OUT:     sig_o  = OUT_CODE;
      CAPT:    done   = 1'b1;
      default: ;
    endcase
  end

  // Operands and sign are captured only on acceptance so later src changes are inert.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      op_a <= '0;
      op_b <= '0;
      neg  <= 1'b0;
    end else begin
      if (accept) begin
`ifdef MULT_SIGNED_EN
        op_a <= op_signed ? mag(src_a) : src_a;
        op_b <= op_signed ? mag(src_b) : src_b;
        neg  <= op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
`else
        op_a <= src_a;
        op_b <= src_b;
        neg  <= 1'b0;
`endif
      end
      if (state == ITER) cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign mul.mul_load   = load_o;
  assign mul.mul_signal = sig_o;
  assign mul.mul_a      = op_a;
  assign mul.mul_b      = op_b;

  assign wdata = neg ? (~mul.mul_result + 1'b1) : mul.mul_result;

  hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .clk     (clk),
    .clr     (reset),
    .we      (state == CAPT),
    .wdata   (wdata),
    .rd_fn   (rd_fn),
    .rd_data (rd_data),
    .hi      (hi),
    .lo      (lo)
  );

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer with a behavioural shift-add multiplier on the bus;
// expected HI/LO pushed at issue time, checked by a done-driven monitor.
module tb_mult_sequencer;
  import mult_defs::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         op_signed = 1'b0;
  logic [5:0]   rd_fn = 6'd0;
  logic         ready, done;
  logic [W-1:0] rd_data, hi, lo;

  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int unsigned  t;
  } exp_t;

  exp_t        q[$];
  exp_t        pend;
  logic        pend_valid = 1'b0;
  int unsigned multu_n = 0;

  mult_sequencer_if #(.WIDTH(W)) mif ();

  mult_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_a     (src_a),
    .src_b     (src_b),
`ifdef MULT_SIGNED_EN
    .op_signed (op_signed),
`endif
    .ready     (ready),
    .done      (done),
    .mul       (mif.master),
    .rd_fn     (rd_fn),
    .rd_data   (rd_data),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shift-add multiplier model
  logic [2*W-1:0] m_cand = '0, m_acc = '0, m_prod = '0;
  logic [W-1:0]   m_plier = '0;
  always @(posedge clk) begin
    if (mif.mul_load) begin
      m_cand  <= {{W{1'b0}}, mif.mul_a};
      m_plier <= mif.mul_b;
      m_acc   <= '0;
    end else if (mif.mul_signal == MULTU_CODE) begin
      if (m_plier[0]) m_acc <= m_acc + m_cand;
      m_cand  <= m_cand << 1;
      m_plier <= m_plier >> 1;
    end else if (mif.mul_signal == OUT_CODE) begin
      m_prod <= m_acc;
    end
  end
  assign mif.mul_result = m_prod;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (mif.mul_load) multu_n = 0;
      if (mif.mul_signal == MULTU_CODE) multu_n++;
      if (pend_valid) begin
        chk("hi", 64'(hi), 64'(pend.hi));
        chk("lo", 64'(lo), 64'(pend.lo));
        pend_valid = 1'b0;
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(1), 64'(0));
        end else begin
          pend = q.pop_front();
          chk("done_latency", 64'(cyc - pend.t), 64'(34));
          chk("multu_cycles", 64'(multu_n), 64'(32));
          pend_valid = 1'b1;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_t e;
    int   n;
    start = 1'b1;
    src_a = a;
    src_b = b;
    op_signed = s;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    e.hi = eh;
    e.lo = el;
    e.t  = cyc;
    q.push_back(e);
    start = 1'b0;
    src_a = ~a;
    src_b = ~b;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || pend_valid || !ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n < 200), 64'(1));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 64'(done), 64'(1));
  endtask

  initial begin
    // 1. reset
    rd_fn = MFHI_FN;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hilo", {hi, lo}, 64'(0));
    chk("rst_signal", 64'(mif.mul_signal), 64'(0));
    chk("rst_load", 64'(mif.mul_load), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // 2. small unsigned
    issue(32'd7, 32'd6, 1'b0, 32'd0, 32'd42);
    wait_idle();

    // 3. max unsigned and read mux
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_idle();
    rd_fn = MFLO_FN; #1;
    chk("rd_mflo", 64'(rd_data), 64'h1);
    rd_fn = 6'd5; #1;
    chk("rd_other", 64'(rd_data), 64'h0);
    rd_fn = MFHI_FN; #1;
    chk("rd_mfhi", 64'(rd_data), 64'hFFFF_FFFE);

    // 4. busy start ignored, done-cycle read sees old value, back-to-back
    issue(32'h1234_5678, 32'h10, 1'b0, 32'h1, 32'h2345_6780);
    repeat (3) @(negedge clk);
    start = 1'b1;
    src_a = 32'hDEAD_BEEF;
    src_b = 32'h0BAD_F00D;
    repeat (5) @(negedge clk);
    start = 1'b0;
    rd_fn = MFLO_FN;
    wait_done();
    chk("rd_in_done_old", 64'(rd_data), 64'h1);
    issue(32'd100, 32'd200, 1'b0, 32'd0, 32'd20000);
    chk("b2b_ready_low", 64'(ready), 64'(0));
    wait_idle();

    // 5. reset at counter=10 aborts and clears
    issue(32'd9, 32'd9, 1'b0, 32'd0, 32'd81);
    repeat (11) @(negedge clk);
    chk("abort_in_iter", 64'(mif.mul_signal), 64'(MULTU_CODE));
    reset = 1'b1;
    @(negedge clk);
    void'(q.pop_back());
    chk("abort_ready", 64'(ready), 64'(1));
    chk("abort_hilo", {hi, lo}, 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd3, 32'd5, 1'b0, 32'd0, 32'd15);
    wait_idle();

`ifdef MULT_SIGNED_EN
    // 6. signed
    issue(-32'sd3, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000);
    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000);
    wait_idle();
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
